ov5640_capture_display: RTL and testbench
=========================================

# ov5640_capture_display

Single-clock bridge from an OV5640 DVP camera to an RGB565 TFT panel. It generates the camera master clock and power sequence, oversamples the camera pixel bus in the system clock domain, and stores a 160x128 RGB565 frame in on-chip RAM. It scans that frame out to a 480x272 TFT, with the image in the top-left corner and black elsewhere. SCCB register configuration is handled outside this block; the SCCB pins are held idle.

## Interface
- PWR_DLY, 50_000: clk cycles from reset release to PWDN deassert.
- RST_DLY, 100_000: clk cycles from reset release to Camera_Rst_n release.
- IMG_W, 160 / IMG_H, 128: captured frame size in pixels.

- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- Camera_PCLK  in  1  camera pixel clock (≤ clk/4), sampled as data, not used as a clock
- Camera_Vsync  in  1  frame sync, active-high pulse before each frame
- Camera_Href  in  1  line valid
- Camera_Data  in  8  pixel byte, 2 bytes per RGB565 pixel
- Camera_XCLK  out  1  clk/2
- Camera_Rst_n  out  1  camera reset, active-low
- Camera_PWDN  out  1  camera power-down, active-high
- Camera_sclk  out  1  SCCB clock, held 1
- Camera_sdat  inout  1  SCCB data, held high-Z
- TFT_RGB  out  16  RGB565 pixel
- TFT_VS / TFT_HS  out  1  syncs, active-low
- TFT_CLK  out  1  pixel clock, clk/4
- TFT_DE  out  1  data enable

## Operation
- Reset values:
  - XCLK=0, Camera_Rst_n=0, PWDN=1, sclk=1, sdat=Z.
  - TFT_RGB=0, VS=1, HS=1, TFT_CLK=0, DE=0.
- Power sequence: a counter starts at reset release.
  - PWDN goes to 0 at PWR_DLY.
  - Camera_Rst_n goes to 1 at RST_DLY.
  - Both then hold until reset.
- Capture runs independently of the power sequence.
- Input synchronisation:
  - PCLK, Vsync, Href and Data pass through an identical 2-flop synchroniser.
  - A byte is taken on the synchronised PCLK rising edge while synchronised Href=1.
- Pixel assembly and addressing:
  - Byte order within a pixel: first byte = RGB[15:8], second = RGB[7:0].
  - A byte toggle clears when Href=0.
  - The write address resets to 0 on each synchronised Vsync falling edge.
  - Column counter 0..IMG_W-1 increments per completed pixel and clears on Href falling edge; row counter increments on Href falling edge.
  - A pixel is written at row*IMG_W+col only if col<IMG_W and row<IMG_H; excess pixels and lines are dropped.
- Frame buffer: IMG_W*IMG_H x 16 RAM, one write port and one registered read port, both on clk. Partial frames overwrite in place, with no double buffering.
- TFT scan timing (counts in TFT_CLK periods):
  - H: sync 41, back porch 2, active 480, front porch 2; total 525.
  - V: sync 10 lines, back porch 2, active 272, front porch 2; total 286.
- TFT output rules:
  - DE=1 exactly in active H and V.
  - RGB = frame-buffer pixel when active x<IMG_W and y<IMG_H, otherwise 0; RGB=0 whenever DE=0.

## Timing
- TFT_CLK is high for 2 clk and low for 2 clk.
- All TFT outputs update on the clk where TFT_CLK falls, so they are stable around the rising edge.
- RAM read is issued one pixel period ahead, so the RGB/DE/HS/VS pipeline stays aligned, with no skew between them.
- Capture latency, byte to RAM write: ≤ 5 clk after the PCLK rising edge reaches the pins.
- RAM read/write collision on the same address: the read returns old data; this is acceptable.
- Async reset mid-frame clears all counters. Capture resumes at the next Vsync falling edge; until then the write address is 0 and the column counter stays frozen until Href.

## Structure
- Shared package holds:
  - IMG_W/IMG_H.
  - TFT timing constants (H_SYNC, H_BACK, H_ACTIVE, H_FRONT, H_TOTAL and the V equivalents).
  - The RGB565 pixel typedef.
- Sub-module `tft_timing_gen` is the natural split. It contains the clk/4 enable, H/V counters, syncs, DE and pixel x/y outputs.
- Capture, RAM and power sequencing live in the top.

## Test plan
- Reset held then released:
  - all outputs at reset values.
  - PWDN falls at exactly PWR_DLY cycles.
  - Rst_n rises at RST_DLY (reduce both to 20/40 in the bench).
- Vsync pulse, then 128 Href lines of 320 bytes incrementing from 1, PCLK 12.5 MHz:
  - RAM[0]=0x0102, RAM[1]=0x0304, RAM[159]=0x3F40.
  - RAM[160] = next line's first pair.
- Line of 400 bytes (200 pixels): only columns 0..159 written, and the next line starts at col 0.
- TFT scan: HS low for 41 TFT_CLK, DE high for 480, line period 525 TFT_CLK; VS low for 10 lines; frame period 286 lines.
- After capture, during active scan:
  - x=0,y=0 outputs RAM[0].
  - x=159,y=127 outputs RAM[20479].
  - x=160 or y=128 outputs 0.
- Reset asserted mid-line, then released:
  - no RAM writes until the next Vsync falling edge.
  - Camera_Rst_n low again and the power sequence restarts.

Source files
------------

// File: rtl/ov5640_capture_display_pkg.sv
// Shared constants and types for the OV5640 capture / TFT display bridge.
package ov5640_capture_display_pkg;

    localparam int IMG_W    = 160;
    localparam int IMG_H    = 128;
    localparam int FB_DEPTH = IMG_W * IMG_H;
    localparam int FB_AW    = $clog2(FB_DEPTH);

    // TFT timing, in TFT_CLK periods (H) and lines (V)
    localparam int H_SYNC   = 41;
    localparam int H_BACK   = 2;
    localparam int H_ACTIVE = 480;
    localparam int H_FRONT  = 2;
    localparam int H_TOTAL  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;

    localparam int V_SYNC   = 10;
    localparam int V_BACK   = 2;
    localparam int V_ACTIVE = 272;
    localparam int V_FRONT  = 2;
    localparam int V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    typedef logic [15:0] rgb565_t;

    // Linear frame-buffer address of an in-image pixel.
    function automatic logic [FB_AW-1:0] fb_addr(input logic [7:0] col, input logic [7:0] row);
        return FB_AW'(row) * FB_AW'(IMG_W) + FB_AW'(col);
    endfunction

endpackage

// File: rtl/ov5640_capture_display_tft_timing_gen.sv
// TFT scan timing: clk/4 pixel clock, H/V counters, syncs, DE and the
// coordinates of the pixel that will be presented at the next pixel tick.
module tft_timing_gen
    import ov5640_capture_display_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    output logic          tft_clk,
    output logic          pix_en,
    output logic          tft_hs,
    output logic          tft_vs,
    output logic          tft_de,
    output logic          nxt_active,
    output logic [HW-1:0] nxt_x,
    output logic [VW-1:0] nxt_y
);

    logic [1:0]    div_cnt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_act;
    logic          v_act;

    // div_cnt[1] gives 2 clk high / 2 clk low; outputs move on the clk where it falls
    assign tft_clk = div_cnt[1];
    assign pix_en  = (div_cnt == 2'd3);

    // clk/4 divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_cnt <= '0;
        else        div_cnt <= div_cnt + 2'd1;
    end

    // h/v position of the pixel being prepared; advances once per pixel period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == HW'(H_TOTAL - 1)) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    assign h_act = (h_cnt >= HW'(H_SYNC + H_BACK)) && (h_cnt < HW'(H_SYNC + H_BACK + H_ACTIVE));
    assign v_act = (v_cnt >= VW'(V_SYNC + V_BACK)) && (v_cnt < VW'(V_SYNC + V_BACK + V_ACTIVE));

    assign nxt_active = h_act && v_act;
    assign nxt_x      = h_cnt - HW'(H_SYNC + H_BACK);
    assign nxt_y      = v_cnt - VW'(V_SYNC + V_BACK);

    // registered syncs and DE, updated together with the pixel data in the top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tft_hs <= 1'b1;
            tft_vs <= 1'b1;
            tft_de <= 1'b0;
        end else if (pix_en) begin
            tft_hs <= (h_cnt >= HW'(H_SYNC));
            tft_vs <= (v_cnt >= VW'(V_SYNC));
            tft_de <= h_act && v_act;
        end
    end

endmodule

// File: rtl/ov5640_capture_display.sv
// OV5640 DVP capture into a 160x128 RGB565 frame buffer, scanned out to the
// top-left corner of a 480x272 TFT. Camera inputs are oversampled on clk.
module ov5640_capture_display
    import ov5640_capture_display_pkg::*;
#(
    parameter int PWR_DLY = 50_000,
    parameter int RST_DLY = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Camera_PCLK,
    input  logic       Camera_Vsync,
    input  logic       Camera_Href,
    input  logic [7:0] Camera_Data,
    output logic       Camera_XCLK,
    output logic       Camera_Rst_n,
    output logic       Camera_PWDN,
    output logic       Camera_sclk,
    inout  wire        Camera_sdat,
    output rgb565_t    TFT_RGB,
    output logic       TFT_VS,
    output logic       TFT_HS,
    output logic       TFT_CLK,
    output logic       TFT_DE
);

    localparam int PCW = $clog2(RST_DLY + 1);

    logic [PCW-1:0] pwr_cnt;
    logic           xclk;

    // power-up down-counter; both camera controls are terminal-count compares
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               pwr_cnt <= PCW'(RST_DLY);
        else if (pwr_cnt != '0)   pwr_cnt <= pwr_cnt - PCW'(1);
    end

    assign Camera_PWDN  = (pwr_cnt > PCW'(RST_DLY - PWR_DLY));
    assign Camera_Rst_n = (pwr_cnt == '0);

    // camera master clock, clk/2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) xclk <= 1'b0;
        else        xclk <= ~xclk;
    end

    assign Camera_XCLK = xclk;
    assign Camera_sclk = 1'b1;
    assign Camera_sdat = 1'bz;

    logic [10:0] cam_s1;
    logic [10:0] cam_s2;
    logic        pclk_s, vsync_s, href_s;
    logic [7:0]  data_s;
    logic        pclk_d, vsync_d, href_d;

    // identical 2-flop synchroniser on every camera input keeps data aligned to PCLK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam_s1 <= '0;
            cam_s2 <= '0;
        end else begin
            cam_s1 <= {Camera_PCLK, Camera_Vsync, Camera_Href, Camera_Data};
            cam_s2 <= cam_s1;
        end
    end

    assign {pclk_s, vsync_s, href_s, data_s} = cam_s2;

    // one more stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pclk_d  <= 1'b0;
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
        end else begin
            pclk_d  <= pclk_s;
            vsync_d <= vsync_s;
            href_d  <= href_s;
        end
    end

    logic       byte_en, pixel_done, href_fall, vsync_fall;
    logic       armed, byte_sel;
    logic [7:0] hi_byte;
    logic [7:0] col, row;
    logic       fb_we;
    logic [FB_AW-1:0] wr_addr;

    assign byte_en    = pclk_s && !pclk_d && href_s;
    assign pixel_done = byte_en && byte_sel;
    assign href_fall  = href_d && !href_s;
    assign vsync_fall = vsync_d && !vsync_s;

    // pixel assembly and position tracking; nothing moves until the first Vsync
    // falling edge after reset, so a frame interrupted by reset is never resumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            byte_sel <= 1'b0;
            hi_byte  <= '0;
            col      <= '0;
            row      <= '0;
        end else if (vsync_fall) begin
            armed    <= 1'b1;
            byte_sel <= 1'b0;
            col      <= '0;
            row      <= '0;
        end else if (armed) begin
            if (!href_s) begin
                byte_sel <= 1'b0;
            end else if (byte_en) begin
                byte_sel <= ~byte_sel;
                if (!byte_sel) hi_byte <= data_s;
            end
            if (href_fall) begin
                col <= '0;
                if (row != 8'(IMG_H)) row <= row + 8'd1;
            end else if (pixel_done && col != 8'(IMG_W)) begin
                col <= col + 8'd1;
            end
        end
    end

    assign fb_we   = armed && pixel_done && (col < 8'(IMG_W)) && (row < 8'(IMG_H));
    assign wr_addr = fb_addr(col, row);

    logic          pix_en, nxt_active, in_img;
    logic [HW-1:0] nxt_x;
    logic [VW-1:0] nxt_y;
    logic [FB_AW-1:0] rd_addr;
    rgb565_t       rd_data;
    rgb565_t       fb_mem [FB_DEPTH];

    tft_timing_gen u_tim (
        .clk        (clk),
        .rst_n      (rst_n),
        .tft_clk    (TFT_CLK),
        .pix_en     (pix_en),
        .tft_hs     (TFT_HS),
        .tft_vs     (TFT_VS),
        .tft_de     (TFT_DE),
        .nxt_active (nxt_active),
        .nxt_x      (nxt_x),
        .nxt_y      (nxt_y)
    );

    // the read address follows the upcoming pixel, so rd_data is settled at pix_en
    assign in_img  = nxt_active && (nxt_x < HW'(IMG_W)) && (nxt_y < VW'(IMG_H));
    assign rd_addr = in_img ? fb_addr(nxt_x[7:0], nxt_y[7:0]) : '0;

    // frame buffer: one write port, one registered read port
    always_ff @(posedge clk) begin
        if (fb_we) fb_mem[wr_addr] <= {hi_byte, data_s};
        rd_data <= fb_mem[rd_addr];
    end

    // pixel output, black outside the image and outside active video
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      TFT_RGB <= '0;
        else if (pix_en) TFT_RGB <= in_img ? rd_data : '0;
    end

endmodule

// File: tb/tb_ov5640_capture_display.sv
// Directed bench for ov5640_capture_display with short power-up delays.
module tb_ov5640_capture_display;

    localparam int PWR = 20;
    localparam int RST = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Camera_PCLK, Camera_Vsync, Camera_Href;
    logic [7:0]  Camera_Data;
    logic        Camera_XCLK, Camera_Rst_n, Camera_PWDN, Camera_sclk;
    wire         Camera_sdat;
    logic [15:0] TFT_RGB;
    logic        TFT_VS, TFT_HS, TFT_CLK, TFT_DE;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;
    int byte_idx = 0;

    ov5640_capture_display #(.PWR_DLY(PWR), .RST_DLY(RST)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Camera_PCLK  (Camera_PCLK),
        .Camera_Vsync (Camera_Vsync),
        .Camera_Href  (Camera_Href),
        .Camera_Data  (Camera_Data),
        .Camera_XCLK  (Camera_XCLK),
        .Camera_Rst_n (Camera_Rst_n),
        .Camera_PWDN  (Camera_PWDN),
        .Camera_sclk  (Camera_sclk),
        .Camera_sdat  (Camera_sdat),
        .TFT_RGB      (TFT_RGB),
        .TFT_VS       (TFT_VS),
        .TFT_HS       (TFT_HS),
        .TFT_CLK      (TFT_CLK),
        .TFT_DE       (TFT_DE)
    );

    always #10 clk = ~clk;

    always @(posedge clk) if (dut.fb_we === 1'b1) we_cnt++;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one PCLK period = 4 clk; data changes with the falling edge
    task automatic send_byte(input logic [7:0] b);
        Camera_Data = b;
        Camera_PCLK = 1'b0;
        clk_n(2);
        Camera_PCLK = 1'b1;
        clk_n(2);
        Camera_PCLK = 1'b0;
    endtask

    // bytes carry the running value byte_idx+1
    task automatic send_line(input int nbytes);
        Camera_Href = 1'b1;
        clk_n(4);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(8'(byte_idx + 1));
            byte_idx++;
        end
        clk_n(4);
        Camera_Href = 1'b0;
        clk_n(6);
    endtask

    task automatic vsync_pulse();
        Camera_Vsync = 1'b1;
        clk_n(8);
        Camera_Vsync = 1'b0;
        clk_n(8);
    endtask

    // called right after rst_n is released on a falling clk edge
    task automatic check_power();
        for (int k = 1; k <= RST + 2; k++) begin
            @(posedge clk); #1;
            if (k == PWR - 1) check_val("pwdn_before_dly", 32'(Camera_PWDN), 1);
            if (k == PWR)     check_val("pwdn_at_dly", 32'(Camera_PWDN), 0);
            if (k == RST - 1) check_val("cam_rst_before_dly", 32'(Camera_Rst_n), 0);
            if (k == RST)     check_val("cam_rst_at_dly", 32'(Camera_Rst_n), 1);
            if (k == RST + 2) check_val("pwdn_held", 32'(Camera_PWDN), 0);
        end
    endtask

    // advance to the next clk on which TFT_CLK has fallen (TFT outputs just updated)
    task automatic next_tick();
        logic prev;
        prev = TFT_CLK;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (prev && !TFT_CLK) break;
            prev = TFT_CLK;
        end
    endtask

    // entered on an HS-falling tick, returns on the next one
    task automatic scan_line(output int hs_low, output int de_n, output int period,
                             output logic [15:0] p0, output logic [15:0] p159,
                             output logic [15:0] p160, output logic blank_bad);
        logic prev_hs;
        int   x;
        hs_low = 0; de_n = 0; period = 0; x = 0; blank_bad = 1'b0;
        p0 = 'x; p159 = 'x; p160 = 'x;
        do begin
            if (!TFT_HS) hs_low++;
            if (TFT_DE) begin
                if (x == 0)   p0   = TFT_RGB;
                if (x == 159) p159 = TFT_RGB;
                if (x == 160) p160 = TFT_RGB;
                x++;
                de_n++;
            end else if (TFT_RGB != 16'h0) begin
                blank_bad = 1'b1;
            end
            prev_hs = TFT_HS;
            next_tick();
            period++;
        end while (!(prev_hs && !TFT_HS) && period < 1000);
    endtask

    task automatic capture_frame();
        vsync_pulse();
        we_cnt = 0;
        send_line(320);
        check_val("line0_writes", we_cnt, 160);
        we_cnt = 0;
        send_line(400);
        check_val("long_line_writes", we_cnt, 160);
        send_line(4);
        repeat (124) send_line(0);
        send_line(320);
        we_cnt = 0;
        send_line(8);
        check_val("excess_line_writes", we_cnt, 0);
        check_val("ram0", 32'(dut.fb_mem[0]), 32'h0102);
        check_val("ram1", 32'(dut.fb_mem[1]), 32'h0304);
        check_val("ram159", 32'(dut.fb_mem[159]), 32'h3F40);
        check_val("ram160", 32'(dut.fb_mem[160]), 32'h4142);
        check_val("ram319", 32'(dut.fb_mem[319]), 32'h7F80);
        check_val("ram320_after_long", 32'(dut.fb_mem[320]), 32'hD1D2);
        check_val("ram20320", 32'(dut.fb_mem[20320]), 32'hD5D6);
        check_val("ram20479", 32'(dut.fb_mem[20479]), 32'h1314);
    endtask

    task automatic tft_monitor();
        int n, hs_low, de_n, period;
        logic [15:0] p0, p159, p160;
        logic blank_bad;
        n = 0;
        while (TFT_VS !== 1'b0 && n < 100) begin next_tick(); n++; end
        n = 0;
        while (TFT_VS === 1'b0 && n < 6000) begin next_tick(); n++; end
        check_val("vs_low_ticks", n, 10 * 525);
        // lines 10 and 11: vertical back porch
        scan_line(hs_low, de_n, period, p0, p159, p160, blank_bad);
        check_val("l10_hs_low", hs_low, 41);
        check_val("l10_period", period, 525);
        check_val("l10_de", de_n, 0);
        scan_line(hs_low, de_n, period, p0, p159, p160, blank_bad);
        check_val("l11_de", de_n, 0);
        // y = 0
        scan_line(hs_low, de_n, period, p0, p159, p160, blank_bad);
        check_val("y0_hs_low", hs_low, 41);
        check_val("y0_de", de_n, 480);
        check_val("y0_period", period, 525);
        check_val("y0_x0", 32'(p0), 32'h0102);
        check_val("y0_x159", 32'(p159), 32'h3F40);
        check_val("y0_x160", 32'(p160), 32'h0000);
        check_val("y0_blank", 32'(blank_bad), 0);
        // y = 1
        scan_line(hs_low, de_n, period, p0, p159, p160, blank_bad);
        check_val("y1_x0", 32'(p0), 32'h4142);
        check_val("y1_x159", 32'(p159), 32'h7F80);
        check_val("y1_x160", 32'(p160), 32'h0000);
        // y = 2
        scan_line(hs_low, de_n, period, p0, p159, p160, blank_bad);
        check_val("y2_x0", 32'(p0), 32'hD1D2);
    endtask

    task automatic reset_mid_line();
        Camera_Href = 1'b1;
        clk_n(4);
        for (int i = 0; i < 6; i++) send_byte(8'h55);
        rst_n = 1'b0;
        clk_n(3);
        check_val("midrst_cam_rst", 32'(Camera_Rst_n), 0);
        check_val("midrst_pwdn", 32'(Camera_PWDN), 1);
        check_val("midrst_de", 32'(TFT_DE), 0);
        check_val("midrst_hs", 32'(TFT_HS), 1);
        rst_n = 1'b1;
        check_power();
        we_cnt = 0;
        for (int i = 0; i < 6; i++) send_byte(8'hEE);
        clk_n(4);
        Camera_Href = 1'b0;
        clk_n(6);
        send_line(320);
        check_val("no_write_before_vsync", we_cnt, 0);
        vsync_pulse();
        byte_idx = 8'hA9;
        we_cnt = 0;
        send_line(4);
        check_val("resume_writes", we_cnt, 2);
        check_val("resume_ram0", 32'(dut.fb_mem[0]), 32'hAAAB);
        check_val("resume_ram1", 32'(dut.fb_mem[1]), 32'hACAD);
    endtask

    initial begin
        rst_n        = 1'b0;
        Camera_PCLK  = 1'b0;
        Camera_Vsync = 1'b0;
        Camera_Href  = 1'b0;
        Camera_Data  = 8'h00;
        clk_n(5);
        check_val("rst_xclk", 32'(Camera_XCLK), 0);
        check_val("rst_cam_rst", 32'(Camera_Rst_n), 0);
        check_val("rst_pwdn", 32'(Camera_PWDN), 1);
        check_val("rst_sclk", 32'(Camera_sclk), 1);
        check_val("rst_rgb", 32'(TFT_RGB), 0);
        check_val("rst_vs", 32'(TFT_VS), 1);
        check_val("rst_hs", 32'(TFT_HS), 1);
        check_val("rst_tft_clk", 32'(TFT_CLK), 0);
        check_val("rst_de", 32'(TFT_DE), 0);
        rst_n = 1'b1;
        fork
            begin
                check_power();
                capture_frame();
            end
            tft_monitor();
        join
        reset_mid_line();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
